// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: streams sequential words to the ISA decoder with stall, branch redirect and halt.
// Define IFU_PERF_CNT_EN to build the instr_cnt/stall_cnt performance counters; otherwise both read 0.
module instr_fetch_unit #(
    parameter int dwidth_inst = 32,
    parameter int dwidth_pc   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   imem_en,
    output logic [dwidth_pc-1:0]   imem_addr,
    input  logic [dwidth_inst-1:0] imem_rdata,
    output logic [dwidth_inst-1:0] instr,
    output logic                   instr_valid,
    input  logic                   is_not_vect,
    input  logic                   branch_taken,
    input  logic [11:0]            branch_immediate,
    input  logic                   ap_done,
    output logic                   done_steady,
    output logic [dwidth_pc-1:0]   pc,
    output logic [31:0]            instr_cnt,
    output logic [31:0]            stall_cnt,
    output logic [1:0]             fsm_state
);

    // Handshake: instr/pc are consumed on every cycle with instr_valid & is_not_vect; while
    // is_not_vect=0 nothing moves and the memory read is suppressed so imem_rdata holds instr.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [dwidth_pc-1:0]   fetch_ptr;
    logic                   valid_q;
    logic                   live;
    logic                   halt_req;
    logic                   redirect;
    logic                   start_accept;
    logic [31:0]            br_off;
    logic [dwidth_pc-1:0]   br_target;
    logic                   unused_bits;

    assign fsm_state    = state;
    assign live         = (state == S_RUN) && valid_q;
    assign halt_req     = ap_done && live;
    assign redirect     = branch_taken && live && is_not_vect && !ap_done;
    assign start_accept = start && ((state == S_IDLE) || (state == S_HALT));

    // imm[12:1] is a byte offset; dropping bit 1 gives the word offset, wrapped to the PC width.
    assign br_off      = {{21{branch_immediate[11]}}, branch_immediate[11:1]};
    assign br_target   = pc + br_off[dwidth_pc-1:0];
    assign unused_bits = ^{branch_immediate[0], br_off[31:dwidth_pc]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_FILL;
            S_FILL:  state_nxt = S_RUN;
            S_RUN:   if (halt_req) state_nxt = S_HALT;
            S_HALT:  if (start) state_nxt = S_FILL;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_en     = 1'b0;
        imem_addr   = '0;
        instr_valid = 1'b0;
        instr       = '0;
        done_steady = 1'b0;
        unique case (state)
            S_FILL: begin
                imem_en     = 1'b1;
                done_steady = 1'b1;
            end
            S_RUN: begin
                done_steady = 1'b1;
                instr_valid = live;
                instr       = live ? imem_rdata : '0;
                imem_en     = is_not_vect && !halt_req && !redirect;
                imem_addr   = fetch_ptr;
            end
            default: begin
                imem_en = 1'b0;
            end
        endcase
    end

    // A redirect only loads the target; the bubble cycle that follows performs its fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ptr <= '0;
            pc        <= '0;
            valid_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        fetch_ptr <= '0;
                        pc        <= '0;
                        valid_q   <= 1'b0;
                    end
                end
                S_FILL: begin
                    fetch_ptr <= dwidth_pc'(1);
                    pc        <= '0;
                    valid_q   <= 1'b1;
                end
                S_RUN: begin
                    if (halt_req) begin
                        valid_q <= 1'b0;
                    end else if (redirect) begin
                        fetch_ptr <= br_target;
                        valid_q   <= 1'b0;
                    end else if (is_not_vect) begin
                        pc        <= fetch_ptr;
                        fetch_ptr <= fetch_ptr + dwidth_pc'(1);
                        valid_q   <= 1'b1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (start_accept) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (live && is_not_vect && (instr_cnt_q != '1)) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
            if ((state == S_RUN) && !is_not_vect && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a stimulus thread pushes expected {pc, instr} pairs and a
// negedge monitor pops one on every consumed instruction; direct checks cover reset, stall, bubble and halt.
module tb_instr_fetch_unit;

    localparam int W_PC   = 10;
    localparam int W_INST = 32;
`ifdef IFU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              imem_en;
    logic [W_PC-1:0]   imem_addr;
    logic [W_INST-1:0] imem_rdata = '0;
    logic [W_INST-1:0] instr;
    logic              instr_valid;
    logic              is_not_vect = 1'b1;
    logic              branch_taken = 1'b0;
    logic [11:0]       branch_immediate = '0;
    logic              ap_done = 1'b0;
    logic              done_steady;
    logic [W_PC-1:0]   pc;
    logic [31:0]       instr_cnt;
    logic [31:0]       stall_cnt;
    logic [1:0]        fsm_state;

    logic [W_INST-1:0] mem [0:(1<<W_PC)-1];
    logic [W_PC+W_INST-1:0] exp_q[$];
    logic [W_PC+W_INST-1:0] mon_exp;
    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_unit #(.dwidth_inst(W_INST), .dwidth_pc(W_PC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .imem_en          (imem_en),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .is_not_vect      (is_not_vect),
        .branch_taken     (branch_taken),
        .branch_immediate (branch_immediate),
        .ap_done          (ap_done),
        .done_steady      (done_steady),
        .pc               (pc),
        .instr_cnt        (instr_cnt),
        .stall_cnt        (stall_cnt),
        .fsm_state        (fsm_state)
    );

    // Clock / reset and instruction memory (word k holds k + 0x100).
    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < (1 << W_PC); k++) mem[k] = 32'h100 + k;
    end

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    // Scoreboard monitor: one pop per consumed instruction.
    always @(negedge clk) begin
        if (rst_n && instr_valid && is_not_vect) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL consume: got pc=%0d instr=%h, required no instruction", pc, instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({pc, instr} === mon_exp) n_pass++;
                else $display("FAIL consume: got pc=%0d instr=%h, required pc=%0d instr=%h",
                              pc, instr, mon_exp[W_PC+W_INST-1:W_INST], mon_exp[W_INST-1:0]);
            end
        end
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push_exp(input logic [W_PC-1:0] p, input logic [W_INST-1:0] d);
        exp_q.push_back({p, d});
    endtask

    task automatic wait_pc(input logic [W_PC-1:0] target);
        int n;
        n = 0;
        while (!(instr_valid && pc == target) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            $display("FAIL wait_pc: got timeout, required pc=%0d", target);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        step();
        step();
        check("rst_imem_en", imem_en, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_done_steady", done_steady, 0);
        check("rst_pc", pc, 0);
        check("rst_instr_cnt", instr_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst_n = 1'b1;
        step();

        // Sequential fetch, stall at pc=4, branch at pc=8 back to 6.
        push_exp(10'd0, 32'h100); push_exp(10'd1, 32'h101); push_exp(10'd2, 32'h102);
        push_exp(10'd3, 32'h103); push_exp(10'd4, 32'h104); push_exp(10'd5, 32'h105);
        push_exp(10'd6, 32'h106); push_exp(10'd7, 32'h107); push_exp(10'd8, 32'h108);
        start = 1'b1;
        step();
        start = 1'b0;
        check("fill_imem_en", imem_en, 1);
        check("fill_imem_addr", imem_addr, 0);
        check("fill_done_steady", done_steady, 1);
        check("fill_instr_valid", instr_valid, 0);
        step();
        check("first_valid", instr_valid, 1);
        check("first_pc", pc, 0);
        check("first_instr", instr, 32'h100);

        wait_pc(10'd4);
        is_not_vect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 4);
            check("stall_instr", instr, 32'h104);
            check("stall_imem_en", imem_en, 0);
        end
        check("stall_cnt", stall_cnt, PERF ? 3 : 0);
        is_not_vect = 1'b1;
        step();
        check("after_stall_pc", pc, 5);

        wait_pc(10'd8);
        branch_taken = 1'b1;
        branch_immediate = 12'hFFC;
        push_exp(10'd6, 32'h106); push_exp(10'd7, 32'h107);
        step();
        branch_taken = 1'b0;
        check("bubble1_valid", instr_valid, 0);
        check("bubble1_addr", imem_addr, 6);
        step();
        check("redirect1_pc", pc, 6);
        check("redirect1_valid", instr_valid, 1);

        // Branch from 7 by -8 words wraps the target to 1023, then sequential wrap to 0.
        wait_pc(10'd7);
        branch_taken = 1'b1;
        branch_immediate = 12'hFF0;
        push_exp(10'd1023, 32'h4FF); push_exp(10'd0, 32'h100);
        push_exp(10'd1, 32'h101);    push_exp(10'd2, 32'h102);
        step();
        branch_taken = 1'b0;
        check("bubble2_valid", instr_valid, 0);
        step();
        check("wrap_target_pc", pc, 1023);
        check("wrap_target_instr", instr, 32'h4FF);
        step();
        check("wrap_seq_pc", pc, 0);

        // ap_done together with a taken branch: halt wins, no redirect.
        wait_pc(10'd2);
        ap_done = 1'b1;
        branch_taken = 1'b1;
        branch_immediate = 12'h010;
        step();
        ap_done = 1'b0;
        branch_taken = 1'b0;
        check("halt_valid", instr_valid, 0);
        check("halt_done_steady", done_steady, 0);
        check("halt_imem_en", imem_en, 0);
        check("halt_state", fsm_state, 3);
        step();
        check("halt_hold_valid", instr_valid, 0);
        check("halt_hold_imem_en", imem_en, 0);
        check("halt_instr_cnt", instr_cnt, PERF ? 15 : 0);
        check("halt_stall_cnt", stall_cnt, PERF ? 3 : 0);

        // Restart from HALT, then reset in the middle of RUN.
        push_exp(10'd0, 32'h100); push_exp(10'd1, 32'h101);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_instr_cnt", instr_cnt, 0);
        check("restart_stall_cnt", stall_cnt, 0);
        wait_pc(10'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_imem_en", imem_en, 0);
        check("midrst_imem_addr", imem_addr, 0);
        check("midrst_instr", instr, 0);
        check("midrst_instr_valid", instr_valid, 0);
        check("midrst_pc", pc, 0);
        check("midrst_done_steady", done_steady, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle_valid", instr_valid, 0);
        check("post_rst_idle_en", imem_en, 0);

        push_exp(10'd0, 32'h100); push_exp(10'd1, 32'h101); push_exp(10'd2, 32'h102);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("resume_pc", pc, 0);
        check("resume_instr", instr, 32'h100);
        wait_pc(10'd2);
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        check("final_halt_done_steady", done_steady, 0);
        step();
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter dwidth_inst, default 32, instruction width.
REQ-002 SHALL have parameter dwidth_pc, default 10, instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse launching execution at word address 0.
REQ-006 SHALL have port imem_en  output  1  instruction-memory read enable.
REQ-007 SHALL have port imem_addr  output  dwidth_pc  instruction-memory word address.
REQ-008 SHALL have port imem_rdata  input  dwidth_inst  read data, valid one cycle after an enabled read; holds when imem_en=0.
REQ-009 SHALL have port instr  output  dwidth_inst  instruction presented to the ISA decoder.
REQ-010 SHALL have port instr_valid  output  1  instr is a live instruction.
REQ-011 SHALL have port is_not_vect  input  1  decoder ready; 0 = stall.
REQ-012 SHALL have port branch_taken  input  1  decoded branch of the current instr is taken.
REQ-013 SHALL have port branch_immediate  input  12  B-type offset imm[12:1].
REQ-014 SHALL have port ap_done  input  1  decoder saw WFI.
REQ-015 SHALL have port done_steady  output  1  program executing; drives decoder done_steady.
REQ-016 SHALL have port pc  output  dwidth_pc  word address of the current instr.
REQ-017 SHALL have ports instr_cnt, stall_cnt  output  32 each  performance counters.

Function
REQ-018 SHALL implement FSM IDLE -> FILL (start) -> RUN (after 1 cycle) -> HALT (ap_done) -> FILL (start).
REQ-019 SHALL in IDLE/HALT hold imem_en=0, instr_valid=0, done_steady=0; start ignored in FILL/RUN.
REQ-020 SHALL in FILL drive imem_addr=0, imem_en=1, fetch pointer := 1, done_steady=1.
REQ-021 SHALL in RUN present imem_rdata on instr with instr_valid=1; first instr valid 2 cycles after start.
REQ-022 SHALL advance pc and fetch pointer by 1 per cycle when is_not_vect=1 and no redirect.
REQ-023 SHALL, when is_not_vect=0, drive imem_en=0 and keep instr, pc, imem_addr unchanged (no instruction lost or duplicated).
REQ-024 SHALL on branch_taken & instr_valid & is_not_vect compute target = pc + sext(branch_immediate[11:1]) mod 2^dwidth_pc, fetch target next cycle, and force instr_valid=0 for exactly one cycle (1-bubble penalty).
REQ-025 SHALL wrap fetch pointer and target from 2^dwidth_pc-1 to 0 without error.
REQ-026 SHALL on ap_done & instr_valid enter HALT next cycle, squash the in-flight fetch, drop done_steady; ap_done takes priority over simultaneous branch_taken.
REQ-027 SHALL ignore branch_taken and ap_done when instr_valid=0.
REQ-028 SHALL increment instr_cnt on each cycle with instr_valid & is_not_vect, and stall_cnt on each RUN cycle with is_not_vect=0; both clear on start, saturate at 2^32-1.

Reset
REQ-029 SHALL on rst_n=0 asynchronously enter IDLE, clearing imem_en, imem_addr, instr, instr_valid, pc, done_steady, instr_cnt, stall_cnt to 0.
REQ-030 SHALL on reset mid-RUN abandon the program; only a new start resumes fetch.

Configuration
REQ-031 SHALL compile counters only when macro IFU_PERF_CNT_EN is defined; undefined: instr_cnt and stall_cnt tied to 0 with no counter registers.

Verification
REQ-032 SHALL test: start, no stalls, imem[k]=k+0x100 -> instr 0x100,0x101,... from cycle 2, pc 0,1,2.
REQ-033 SHALL test: is_not_vect=0 for 3 cycles at pc=4 -> instr/pc held at 4, stall_cnt=3, next instr pc=5.
REQ-034 SHALL test: branch_taken at pc=8, branch_immediate=12'hFFC -> one bubble, next instr_valid at pc=6.
REQ-035 SHALL test: pc=2^dwidth_pc-1 sequential -> next pc=0.
REQ-036 SHALL test: ap_done with branch_taken same cycle -> HALT, instr_valid=0, done_steady=0, no redirect.
REQ-037 SHALL test: rst_n low mid-RUN -> all outputs 0 immediately; start after release restarts at pc=0.
